// File: rtl/cv32e40p_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_pkg
// Description : Shared types and constants for the triple-redundant
//               compressed-decoder voter.
//               - c_lane_word_w : width of one lane word
//                                 {illegal, is_compressed, instr[31:0]}
//               - lane_state_e  : per-lane health state
//               - lowest_lane   : 1-based index of the lowest set bit of a
//                                 3-bit lane mask (0 when the mask is empty)
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_pkg;

    localparam int unsigned c_lane_word_w = 34;

    typedef enum logic [1:0] {
        LANE_OK      = 2'd0,
        LANE_SUSPECT = 2'd1,
        LANE_FAILED  = 2'd2
    } lane_state_e;

    function automatic logic [1:0] lowest_lane(input logic [2:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        if (mask[0]) begin
            idx = 2'd1;
        end else if (mask[1]) begin
            idx = 2'd2;
        end else if (mask[2]) begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_tmr_lane_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_tmr_lane_monitor
// Description : Health monitor for one voter lane. Tracks the lane state
//               (OK / SUSPECT / FAILED), the run of consecutive mismatches
//               and a saturating total mismatch counter.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               i_clear        - return to OK and zero all counters
//               i_upd          - an input word was accepted this cycle
//               i_mismatch     - this lane disagreed with the voted word
//               o_state        - current lane state
//               o_err_cnt      - saturating mismatch counter
//               o_enter_fail   - lane becomes FAILED at the next edge
//               o_failed_next  - lane will be FAILED after the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_tmr_lane_monitor
    import cv32e40p_pkg::*;
#(
    parameter int unsigned FAIL_THRESH = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_upd,
    input  logic             i_mismatch,
    output lane_state_e      o_state,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_enter_fail,
    output logic             o_failed_next
);

    localparam logic [3:0]       c_thresh  = 4'(FAIL_THRESH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    lane_state_e      r_state;
    lane_state_e      w_state_nxt;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [3:0]       w_run_inc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // The run only matters below the threshold, so holding at 15 is enough.
    assign w_run_inc = (r_run == 4'hF) ? r_run : r_run + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_cnt_nxt   = r_cnt;
        if (i_clear) begin
            // Clear wins over any simultaneous update.
            w_state_nxt = LANE_OK;
            w_run_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (i_upd) begin
            if (i_mismatch) begin
                w_cnt_nxt = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
                w_run_nxt = w_run_inc;
                case (r_state)
                    // OK goes straight to FAILED when the threshold is 1.
                    LANE_OK, LANE_SUSPECT:
                        w_state_nxt = (w_run_inc >= c_thresh) ? LANE_FAILED : LANE_SUSPECT;
                    LANE_FAILED:
                        w_state_nxt = LANE_FAILED;
                    default:
                        w_state_nxt = LANE_OK;
                endcase
            end else begin
                w_run_nxt = '0;
                if (r_state == LANE_SUSPECT) begin
                    w_state_nxt = LANE_OK;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LANE_OK;
            r_run   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_state       = r_state;
    assign o_err_cnt     = r_cnt;
    assign o_failed_next = (w_state_nxt == LANE_FAILED);
    assign o_enter_fail  = (w_state_nxt == LANE_FAILED) && (r_state != LANE_FAILED);

endmodule
`default_nettype wire

// File: rtl/cv32e40p_compressed_tmr_voter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_compressed_tmr_voter
// Description : Bitwise 2-of-3 majority voter for three redundant compressed
//               instruction decoders, with a one-entry valid/ready output
//               register, per-lane health monitoring, a fault-report
//               handshake and a sticky fatal flag.
// Ports       : clk, rst_n                 - clock, sync active-low reset
//               instr_k_i, is_compressed_k_i,
//               illegal_instr_k_i (k=1..3) - per-lane decoder results
//               valid_i / ready_o          - input handshake
//               valid_o / ready_i          - output handshake
//               instr_o, is_compressed_o,
//               illegal_instr_o            - registered voted result
//               lane_state_o[k-1]          - state of lane k
//               err_cnt_o[k-1]             - mismatch counter of lane k
//               alarm_req_o / alarm_lane_o /
//               alarm_ack_i                - failed-lane report handshake
//               fatal_o                    - sticky loss of majority
//               clear_i                    - clear monitoring and fatal
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_compressed_tmr_voter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned FAIL_THRESH = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_1_i,
    input  logic [31:0]           instr_2_i,
    input  logic [31:0]           instr_3_i,
    input  logic                  is_compressed_1_i,
    input  logic                  is_compressed_2_i,
    input  logic                  is_compressed_3_i,
    input  logic                  illegal_instr_1_i,
    input  logic                  illegal_instr_2_i,
    input  logic                  illegal_instr_3_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [31:0]           instr_o,
    output logic                  is_compressed_o,
    output logic                  illegal_instr_o,
    output logic [2:0][1:0]       lane_state_o,
    output logic [2:0][CNT_W-1:0] err_cnt_o,
    output logic                  alarm_req_o,
    output logic [1:0]            alarm_lane_o,
    input  logic                  alarm_ack_i,
    output logic                  fatal_o,
    input  logic                  clear_i
);

    logic [2:0][c_lane_word_w-1:0] w_lane;
    logic [c_lane_word_w-1:0]      w_voted;
    logic                          w_accept;
    logic                          w_all_diff;
    logic                          w_multi_fail;
    logic [2:0]                    w_enter_fail;
    logic [2:0]                    w_failed_next;
    lane_state_e                   w_state [3];

    logic                          r_valid;
    logic [c_lane_word_w-1:0]      r_word;
    logic [2:0]                    r_pend;
    logic [2:0]                    w_pend_nxt;
    logic [2:0]                    w_ack_mask;
    logic [1:0]                    r_cur;
    logic [1:0]                    w_cur_nxt;
    logic                          r_fatal;
    logic                          w_fatal_nxt;

    assign w_lane[0] = {illegal_instr_1_i, is_compressed_1_i, instr_1_i};
    assign w_lane[1] = {illegal_instr_2_i, is_compressed_2_i, instr_2_i};
    assign w_lane[2] = {illegal_instr_3_i, is_compressed_3_i, instr_3_i};

    assign w_voted = (w_lane[0] & w_lane[1]) |
                     (w_lane[1] & w_lane[2]) |
                     (w_lane[0] & w_lane[2]);

    assign ready_o  = !r_valid || ready_i;
    assign w_accept = valid_i && ready_o;

    assign w_all_diff = (w_lane[0] != w_lane[1]) &&
                        (w_lane[1] != w_lane[2]) &&
                        (w_lane[0] != w_lane[2]);

    // Output register: holds while valid_o && !ready_i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_word  <= w_voted;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o         = r_valid;
    assign instr_o         = r_word[31:0];
    assign is_compressed_o = r_word[32];
    assign illegal_instr_o = r_word[33];

    for (genvar k = 0; k < 3; k++) begin : g_lane
        cv32e40p_tmr_lane_monitor #(
            .FAIL_THRESH (FAIL_THRESH),
            .CNT_W       (CNT_W)
        ) u_mon (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_clear       (clear_i),
            .i_upd         (w_accept),
            .i_mismatch    (w_lane[k] != w_voted),
            .o_state       (w_state[k]),
            .o_err_cnt     (err_cnt_o[k]),
            .o_enter_fail  (w_enter_fail[k]),
            .o_failed_next (w_failed_next[k])
        );
        assign lane_state_o[k] = w_state[k];
    end

    // Judged on the post-update states so lanes failing together are caught
    // on the cycle they fail.
    assign w_multi_fail = (w_failed_next[0] & w_failed_next[1]) |
                          (w_failed_next[1] & w_failed_next[2]) |
                          (w_failed_next[0] & w_failed_next[2]);

    always_comb begin
        w_ack_mask = 3'b000;
        if (alarm_ack_i) begin
            case (r_cur)
                2'd1:    w_ack_mask = 3'b001;
                2'd2:    w_ack_mask = 3'b010;
                2'd3:    w_ack_mask = 3'b100;
                default: w_ack_mask = 3'b000;
            endcase
        end
        // A new failure outranks an ack for the same lane.
        w_pend_nxt = (r_pend & ~w_ack_mask) | w_enter_fail;
        // The presented lane is held until acked, even if a lower lane
        // becomes pending meanwhile.
        if ((r_cur != 2'd0) && !alarm_ack_i) begin
            w_cur_nxt = r_cur;
        end else begin
            w_cur_nxt = lowest_lane(w_pend_nxt);
        end
        w_fatal_nxt = r_fatal | (w_accept && (w_multi_fail || w_all_diff));
        if (clear_i) begin
            w_pend_nxt  = 3'b000;
            w_cur_nxt   = 2'd0;
            w_fatal_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= 3'b000;
            r_cur   <= 2'd0;
            r_fatal <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_cur   <= w_cur_nxt;
            r_fatal <= w_fatal_nxt;
        end
    end

    assign alarm_req_o  = (r_cur != 2'd0);
    assign alarm_lane_o = r_cur;
    assign fatal_o      = r_fatal;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_compressed_tmr_voter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_compressed_tmr_voter
// Description : Self-checking bench for cv32e40p_compressed_tmr_voter.
//               Directed scenarios followed by random traffic, all compared
//               against a behavioural model of the voter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_compressed_tmr_voter;

    localparam int THRESH = 3;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;
    localparam logic [33:0] W = 34'h0_0000_0413;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b0;
    logic [31:0]         instr_1_i = '0, instr_2_i = '0, instr_3_i = '0;
    logic                is_compressed_1_i = 0, is_compressed_2_i = 0, is_compressed_3_i = 0;
    logic                illegal_instr_1_i = 0, illegal_instr_2_i = 0, illegal_instr_3_i = 0;
    logic                valid_i = 0, ready_i = 0, alarm_ack_i = 0, clear_i = 0;
    logic                ready_o, valid_o, is_compressed_o, illegal_instr_o;
    logic [31:0]         instr_o;
    logic [2:0][1:0]     lane_state_o;
    logic [2:0][CW-1:0]  err_cnt_o;
    logic                alarm_req_o, fatal_o;
    logic [1:0]          alarm_lane_o;

    cv32e40p_compressed_tmr_voter #(.FAIL_THRESH(THRESH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_1_i(instr_1_i), .instr_2_i(instr_2_i), .instr_3_i(instr_3_i),
        .is_compressed_1_i(is_compressed_1_i), .is_compressed_2_i(is_compressed_2_i),
        .is_compressed_3_i(is_compressed_3_i),
        .illegal_instr_1_i(illegal_instr_1_i), .illegal_instr_2_i(illegal_instr_2_i),
        .illegal_instr_3_i(illegal_instr_3_i),
        .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .is_compressed_o(is_compressed_o), .illegal_instr_o(illegal_instr_o),
        .lane_state_o(lane_state_o), .err_cnt_o(err_cnt_o),
        .alarm_req_o(alarm_req_o), .alarm_lane_o(alarm_lane_o), .alarm_ack_i(alarm_ack_i),
        .fatal_o(fatal_o), .clear_i(clear_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Lane states as plain integers: 0 OK, 1 SUSPECT, 2 FAILED.
    bit          m_valid;
    logic [33:0] m_word;
    int          m_st  [3];
    int          m_cnt [3];
    int          m_run [3];
    bit          m_pend[3];
    int          m_cur;
    bit          m_fatal;

    function automatic logic [33:0] majority(input logic [33:0] a, input logic [33:0] b,
                                             input logic [33:0] c);
        logic [33:0] r;
        for (int i = 0; i < 34; i++) begin
            int ones;
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_word = '0; m_cur = 0; m_fatal = 0;
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_pend[k] = 0;
        end
    endtask

    task automatic model_step(input logic [33:0] a, input logic [33:0] b, input logic [33:0] c,
                              input bit v, input bit r, input bit ack, input bit clr);
        logic [33:0] lanes [3];
        logic [33:0] vote;
        bit          accept;
        bit          acked;
        bit          newfail [3];
        int          nfailed;
        lanes[0] = a; lanes[1] = b; lanes[2] = c;
        vote   = majority(a, b, c);
        accept = v && (!m_valid || r);
        acked  = ack && (m_cur != 0);
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                m_st[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_pend[k] = 0;
            end
            m_cur = 0; m_fatal = 0;
        end else begin
            for (int k = 0; k < 3; k++) newfail[k] = 0;
            if (accept) begin
                for (int k = 0; k < 3; k++) begin
                    if (lanes[k] != vote) begin
                        if (m_cnt[k] < CMAX) m_cnt[k]++;
                        m_run[k]++;
                        if (m_st[k] != 2) begin
                            if (m_run[k] >= THRESH) begin
                                m_st[k] = 2; newfail[k] = 1;
                            end else begin
                                m_st[k] = 1;
                            end
                        end
                    end else begin
                        m_run[k] = 0;
                        if (m_st[k] == 1) m_st[k] = 0;
                    end
                end
                nfailed = 0;
                for (int k = 0; k < 3; k++) if (m_st[k] == 2) nfailed++;
                if (nfailed >= 2 || (a != b && b != c && a != c)) m_fatal = 1;
            end
            if (acked) m_pend[m_cur-1] = 0;
            for (int k = 0; k < 3; k++) if (newfail[k]) m_pend[k] = 1;
            if (m_cur == 0 || acked) begin
                m_cur = 0;
                for (int k = 2; k >= 0; k--) if (m_pend[k]) m_cur = k + 1;
            end
        end
        if (accept) begin
            m_valid = 1; m_word = vote;
        end else if (r) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid_o", 64'(valid_o), 64'(m_valid));
        check("instr_o", 64'(instr_o), 64'(m_word[31:0]));
        check("is_compressed_o", 64'(is_compressed_o), 64'(m_word[32]));
        check("illegal_instr_o", 64'(illegal_instr_o), 64'(m_word[33]));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lane_state%0d", k + 1), 64'(lane_state_o[k]), 64'(m_st[k]));
            check($sformatf("err_cnt%0d", k + 1), 64'(err_cnt_o[k]), 64'(m_cnt[k]));
        end
        check("alarm_req_o", 64'(alarm_req_o), 64'(m_cur != 0));
        check("alarm_lane_o", 64'(alarm_lane_o), 64'(m_cur));
        check("fatal_o", 64'(fatal_o), 64'(m_fatal));
    endtask

    // One clock: drive at the falling edge, check outputs 1 time unit after
    // the following rising edge.
    task automatic cycle(input logic [33:0] a, input logic [33:0] b, input logic [33:0] c,
                         input bit v, input bit r, input bit ack, input bit clr);
        @(negedge clk);
        {illegal_instr_1_i, is_compressed_1_i, instr_1_i} = a;
        {illegal_instr_2_i, is_compressed_2_i, instr_2_i} = b;
        {illegal_instr_3_i, is_compressed_3_i, instr_3_i} = c;
        valid_i = v; ready_i = r; alarm_ack_i = ack; clear_i = clr;
        #1;
        if (rst_n) begin
            check("ready_o", 64'(ready_o), 64'(!m_valid || r));
            model_step(a, b, c, v, r, ack, clr);
        end else begin
            model_reset();
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    logic [33:0] rb, ra, rc;
    int          bad_lane;

    initial begin
        model_reset();
        rst_n = 1'b0;
        cycle(W, W, W, 1, 1, 0, 0);
        cycle(W, W, W, 1, 1, 0, 0);
        rst_n = 1'b1;

        // Clean word through the voter.
        cycle(W, W, W, 1, 1, 0, 0);
        check("basic_valid", 64'(valid_o), 64'd1);
        check("basic_instr", 64'(instr_o), 64'h413);
        check("basic_cnt2", 64'(err_cnt_o[1]), 64'd0);

        // Single-bit upset on lane 2, then recovery.
        cycle(W, W ^ 34'h1, W, 1, 1, 0, 0);
        check("upset_instr", 64'(instr_o), 64'h413);
        check("upset_state2", 64'(lane_state_o[1]), 64'd1);
        check("upset_cnt2", 64'(err_cnt_o[1]), 64'd1);
        cycle(W, W, W, 1, 1, 0, 0);
        check("recover_state2", 64'(lane_state_o[1]), 64'd0);

        // Lane 3 fails after three consecutive mismatches.
        repeat (3) cycle(W, W, W ^ 34'h100, 1, 1, 0, 0);
        check("fail3_state", 64'(lane_state_o[2]), 64'd2);
        check("fail3_req", 64'(alarm_req_o), 64'd1);
        check("fail3_lane", 64'(alarm_lane_o), 64'd3);
        repeat (2) cycle(W, W, W, 0, 1, 0, 0);
        check("fail3_hold_lane", 64'(alarm_lane_o), 64'd3);
        cycle(W, W, W, 0, 1, 1, 0);
        check("fail3_acked", 64'(alarm_req_o), 64'd0);

        // Backpressure with disagreeing lanes changes nothing.
        cycle(W, W, W, 1, 0, 0, 0);
        repeat (4) cycle(W ^ 34'h1, W ^ 34'h2, W ^ 34'h4, 1, 0, 0, 0);
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_cnt1", 64'(err_cnt_o[0]), 64'd0);
        check("stall_fatal", 64'(fatal_o), 64'd0);
        cycle(W, W, W, 0, 1, 0, 0);

        // All lanes pairwise different -> fatal; clear recovers.
        cycle(W, W, W, 0, 1, 0, 1);
        cycle(34'h1, 34'h2, 34'h4, 1, 1, 0, 0);
        check("alldiff_fatal", 64'(fatal_o), 64'd1);
        check("alldiff_instr", 64'(instr_o), 64'h0);
        cycle(W, W, W, 0, 1, 0, 1);
        check("clear_fatal", 64'(fatal_o), 64'd0);
        check("clear_state1", 64'(lane_state_o[0]), 64'd0);

        // Lanes 1 and 3 fail together: alarms reported lowest first.
        repeat (3) cycle(W ^ 34'h1, W, W ^ 34'h2, 1, 1, 0, 0);
        check("dual_lane_first", 64'(alarm_lane_o), 64'd1);
        check("dual_fatal", 64'(fatal_o), 64'd1);
        cycle(W, W, W, 0, 1, 1, 0);
        check("dual_lane_second", 64'(alarm_lane_o), 64'd3);
        cycle(W, W, W, 0, 1, 1, 0);
        check("dual_done", 64'(alarm_req_o), 64'd0);

        // Counter saturation.
        cycle(W, W, W, 0, 1, 0, 1);
        repeat (20) cycle(W, W ^ 34'h8, W, 1, 1, 0, 0);
        check("sat_cnt2", 64'(err_cnt_o[1]), 64'(CMAX));

        // Reset while data and an alarm are in flight.
        cycle(W, W, W, 0, 1, 0, 1);
        repeat (3) cycle(W, W, W ^ 34'h1, 1, 1, 0, 0);
        cycle(W, W, W, 1, 0, 0, 0);
        rst_n = 1'b0;
        cycle(W, W, W, 1, 0, 0, 0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_alarm", 64'(alarm_req_o), 64'd0);
        check("rst_state3", 64'(lane_state_o[2]), 64'd0);
        rst_n = 1'b1;
        cycle(W, W, W, 0, 0, 0, 0);
        check("rst_ready", 64'(ready_o), 64'd1);

        // Random traffic.
        bad_lane = 0;
        for (int n = 0; n < 3000; n++) begin
            int mode;
            if (n % 60 == 0) bad_lane = $urandom_range(0, 2);
            rb   = {2'($urandom), 32'($urandom)};
            ra   = rb; ra = rb; rc = rb;
            mode = $urandom_range(0, 9);
            if (mode >= 6 && mode <= 8) begin
                int l;
                logic [33:0] flip;
                flip = 34'(1) << $urandom_range(0, 33);
                l = ($urandom_range(0, 1) == 0) ? bad_lane : $urandom_range(0, 2);
                if (l == 0) ra = rb ^ flip;
                else if (l == 1) rb = rb ^ flip;
                else rc = rc ^ flip;
            end else if (mode == 9) begin
                ra = rb ^ 34'h1;
                rc = rb ^ 34'h2;
            end
            cycle(ra, rb, rc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
